// File: rtl/face_scan_controller_if.sv
// Read-port bundle between the scan controller and the two halves of the face
// image buffer; both halves are addressed in lockstep.
interface face_scan_controller_if #(
    parameter int ADDRESS_SIZE = 11,
    parameter int PIXEL_SIZE   = 12
);
    logic [ADDRESS_SIZE-1:0] row_0_pixel_address;
    logic                    row_0_data_valid;
    logic [PIXEL_SIZE-1:0]   row_0_pixel_data;
    logic [ADDRESS_SIZE-1:0] row_1_pixel_address;
    logic                    row_1_data_valid;
    logic [PIXEL_SIZE-1:0]   row_1_pixel_data;

    modport master (
        output row_0_pixel_address,
        output row_0_data_valid,
        input  row_0_pixel_data,
        output row_1_pixel_address,
        output row_1_data_valid,
        input  row_1_pixel_data
    );

    modport slave (
        input  row_0_pixel_address,
        input  row_0_data_valid,
        output row_0_pixel_data,
        input  row_1_pixel_address,
        input  row_1_data_valid,
        output row_1_pixel_data
    );
endinterface

// File: rtl/face_scan_controller.sv
// Scan-out sequencer: reads both image halves row by row, slices pixels into
// BCM bit planes and drives a HUB75-style dual-scan panel.
module face_scan_controller #(
    parameter int NUM_BLOCK_ROWS = 16,
    parameter int NUM_PIXELS     = 128,
    parameter int POWER_MOD      = 16,
    parameter int OE_BASE_CYCLES = 64
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              enable_in,
    face_scan_controller_if.master            image,
    output logic                              r0_out,
    output logic                              g0_out,
    output logic                              b0_out,
    output logic                              r1_out,
    output logic                              g1_out,
    output logic                              b1_out,
    output logic                              shift_clk_out,
    output logic                              latch_out,
    output logic                              oe_n_out,
    output logic [$clog2(NUM_BLOCK_ROWS)-1:0] row_select_out,
    output logic                              frame_done_out
);
    localparam int L            = $clog2(POWER_MOD);
    localparam int ADDRESS_SIZE = $clog2(NUM_BLOCK_ROWS * NUM_PIXELS);
    localparam int LOG_ROWS     = $clog2(NUM_BLOCK_ROWS);
    localparam int COL_W        = $clog2(NUM_PIXELS) + 1;
    localparam int PLANE_W      = (L > 1) ? $clog2(L) : 1;
    localparam int DISP_W       = $clog2((OE_BASE_CYCLES << (L - 1)) + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t              state;
    logic [COL_W-1:0]    col;
    logic                phase;
    logic [LOG_ROWS-1:0] row;
    logic [PLANE_W-1:0]  plane;
    logic [DISP_W-1:0]   disp_count;

    logic [L-1:0] r0_plane, g0_plane, b0_plane, r1_plane, g1_plane, b1_plane;
    assign r0_plane = image.row_0_pixel_data[3*L-1:2*L];
    assign g0_plane = image.row_0_pixel_data[2*L-1:L];
    assign b0_plane = image.row_0_pixel_data[L-1:0];
    assign r1_plane = image.row_1_pixel_data[3*L-1:2*L];
    assign g1_plane = image.row_1_pixel_data[2*L-1:L];
    assign b1_plane = image.row_1_pixel_data[L-1:0];

    function automatic logic [ADDRESS_SIZE-1:0] row_start(input logic [LOG_ROWS-1:0] r);
        return ADDRESS_SIZE'(r) * ADDRESS_SIZE'(NUM_PIXELS);
    endfunction

    logic                last_plane, last_row, frame_end, display_done;
    logic                enter_shift, shift_last;
    logic [PLANE_W-1:0]  next_plane;
    logic [LOG_ROWS-1:0] next_row, entry_row;

    always_comb begin
        last_plane   = (plane == PLANE_W'(L - 1));
        last_row     = (row == LOG_ROWS'(NUM_BLOCK_ROWS - 1));
        frame_end    = last_plane && last_row;
        next_plane   = last_plane ? '0 : plane + 1'b1;
        next_row     = last_plane ? (last_row ? '0 : row + 1'b1) : row;
        display_done = (state == DISPLAY) && (disp_count == '0);
        // enable_in only matters in IDLE or at the frame boundary.
        enter_shift  = ((state == IDLE) && enable_in) ||
                       (display_done && !(frame_end && !enable_in));
        entry_row    = (state == DISPLAY) ? next_row : row;
        shift_last   = (state == SHIFT) && !phase && (col == COL_W'(NUM_PIXELS + 1));
    end

    // NOTE: all state and outputs update in one clocked block with non-blocking
    // assignments, so every output is registered and reads pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                     <= IDLE;
            col                       <= '0;
            phase                     <= 1'b0;
            row                       <= '0;
            plane                     <= '0;
            disp_count                <= '0;
            image.row_0_pixel_address <= '0;
            image.row_1_pixel_address <= '0;
            image.row_0_data_valid    <= 1'b0;
            image.row_1_data_valid    <= 1'b0;
            {r0_out, g0_out, b0_out}  <= '0;
            {r1_out, g1_out, b1_out}  <= '0;
            shift_clk_out             <= 1'b0;
            latch_out                 <= 1'b0;
            oe_n_out                  <= 1'b1;
            row_select_out            <= '0;
            frame_done_out            <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            unique case (state)
                IDLE: begin
                end
                SHIFT: begin
                    // col/phase encode k = 2*col + phase; outputs are set for k+1.
                    phase         <= ~phase;
                    shift_clk_out <= phase && (col != '0);
                    if (phase) begin
                        col <= col + 1'b1;
                        if ((col + 1'b1) < COL_W'(NUM_PIXELS)) begin
                            image.row_0_pixel_address <= row_start(row) + ADDRESS_SIZE'(col + 1'b1);
                            image.row_1_pixel_address <= row_start(row) + ADDRESS_SIZE'(col + 1'b1);
                        end
                    end
                    if (!phase && (col != '0) && (col <= COL_W'(NUM_PIXELS))) begin
                        r0_out <= r0_plane[plane];
                        g0_out <= g0_plane[plane];
                        b0_out <= b0_plane[plane];
                        r1_out <= r1_plane[plane];
                        g1_out <= g1_plane[plane];
                        b1_out <= b1_plane[plane];
                    end
                    if (shift_last) begin
                        state                  <= LATCH;
                        image.row_0_data_valid <= 1'b0;
                        image.row_1_data_valid <= 1'b0;
                        latch_out              <= 1'b1;
                        row_select_out         <= row;
                    end
                end
                LATCH: begin
                    latch_out  <= 1'b0;
                    oe_n_out   <= 1'b0;
                    disp_count <= (DISP_W'(OE_BASE_CYCLES) << plane) - 1'b1;
                    state      <= DISPLAY;
                end
                DISPLAY: begin
                    if (display_done) begin
                        oe_n_out       <= 1'b1;
                        row            <= next_row;
                        plane          <= next_plane;
                        frame_done_out <= frame_end;
                        state          <= IDLE;
                    end else begin
                        disp_count <= disp_count - 1'b1;
                    end
                end
            endcase
            if (enter_shift) begin
                state                     <= SHIFT;
                col                       <= '0;
                phase                     <= 1'b0;
                image.row_0_data_valid    <= 1'b1;
                image.row_1_data_valid    <= 1'b1;
                image.row_0_pixel_address <= row_start(entry_row);
                image.row_1_pixel_address <= row_start(entry_row);
            end
        end
    end
endmodule

// File: tb/tb_face_scan_controller.sv
// Self-checking bench for face_scan_controller: two-stage memory model plus a
// scoreboard of expected colour bits popped at each shift clock rising edge.
module tb_face_scan_controller;
    localparam int N    = 128;
    localparam int ROWS = 16;
    localparam int L    = 4;
    localparam int OE   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic r0, g0, b0, r1, g1, b1, sc, latch, oe_n, frame_done;
    logic [3:0] row_select;

    always #5 clk = ~clk;

    face_scan_controller_if #(.ADDRESS_SIZE(11), .PIXEL_SIZE(12)) img ();

    face_scan_controller #(
        .NUM_BLOCK_ROWS(ROWS),
        .NUM_PIXELS(N),
        .POWER_MOD(16),
        .OE_BASE_CYCLES(OE)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .enable_in(enable),
        .image(img),
        .r0_out(r0),
        .g0_out(g0),
        .b0_out(b0),
        .r1_out(r1),
        .g1_out(g1),
        .b1_out(b1),
        .shift_clk_out(sc),
        .latch_out(latch),
        .oe_n_out(oe_n),
        .row_select_out(row_select),
        .frame_done_out(frame_done)
    );

    // Memory model: 2-cycle read latency, registers enabled by data_valid.
    logic [11:0] mem0 [0:ROWS*N-1];
    logic [11:0] mem1 [0:ROWS*N-1];
    logic [11:0] s0_1 = '0, s0_2 = '0, s1_1 = '0, s1_2 = '0;

    initial begin
        for (int a = 0; a < ROWS*N; a++) begin
            mem0[a] = 12'hF00 | 12'(a % 16);
            mem1[a] = 12'h0F0;
        end
    end

    always @(posedge clk) begin
        if (img.row_0_data_valid) begin
            s0_1 <= mem0[img.row_0_pixel_address];
            s0_2 <= s0_1;
        end
        if (img.row_1_data_valid) begin
            s1_1 <= mem1[img.row_1_pixel_address];
            s1_2 <= s1_1;
        end
    end
    assign img.row_0_pixel_data = s0_2;
    assign img.row_1_pixel_data = s1_2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [5:0] expected_bits(input int row, input int plane, input int col);
        logic [11:0] u, w;
        u = mem0[row*N + col];
        w = mem1[row*N + col];
        return {u[2*L+plane], u[L+plane], u[plane], w[2*L+plane], w[L+plane], w[plane]};
    endfunction

    // Scoreboard / reference model state.
    int cyc = 0, k = 0, edges = 0, oe_run = 0;
    int m_row = 0, m_plane = 0;
    int frame_start_cyc = 0, frame_count = 0, shift_starts = 0, last_exp_addr = 0;
    logic prev_dv = 1'b0, prev_sc = 1'b0, prev_oe = 1'b1, prev_latch = 1'b0;
    logic [5:0] exp_q [$];

    always @(negedge clk) begin : monitor
        logic exp_done;
        int exp_addr;
        logic [5:0] e;
        cyc++;
        exp_done = 1'b0;
        if (rst) begin
            k = 0; edges = 0; oe_run = 0; m_row = 0; m_plane = 0;
            exp_q.delete();
            prev_dv = 1'b0; prev_sc = 1'b0; prev_oe = 1'b1; prev_latch = 1'b0;
        end else begin
            if (!oe_n) oe_run++;
            if (oe_n && !prev_oe) begin
                check("oe_run_length", oe_run, OE << m_plane);
                check("row_select_display", row_select, m_row);
                exp_done = (m_row == ROWS-1) && (m_plane == L-1);
                if (exp_done) check("frame_cycles", cyc - frame_start_cyc, 32000);
                oe_run = 0;
                if (m_plane == L-1) begin
                    m_plane = 0;
                    m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
                end else begin
                    m_plane++;
                end
            end
            if (frame_done || exp_done) begin
                check("frame_done", frame_done, exp_done);
                if (frame_done) frame_count++;
            end
            if (img.row_0_data_valid && !prev_dv) begin
                k = 0; edges = 0; shift_starts++;
                if (m_row == 0 && m_plane == 0) frame_start_cyc = cyc;
                for (int c = 0; c < N; c++) exp_q.push_back(expected_bits(m_row, m_plane, c));
            end
            if (img.row_0_data_valid) begin
                exp_addr = m_row*N + ((k/2 < N) ? k/2 : N-1);
                check("address_0", img.row_0_pixel_address, exp_addr);
                check("address_1", img.row_1_pixel_address, exp_addr);
                check("valid_1", img.row_1_data_valid, 1);
                check("oe_n_during_shift", oe_n, 1);
                last_exp_addr = exp_addr;
                k++;
            end
            if (!img.row_0_data_valid && prev_dv) check("shift_length", k, 2*N+3);
            if (sc && !prev_sc) begin
                edges++;
                if (exp_q.size() == 0) begin
                    check("shift_edge_count", edges, N);
                end else begin
                    e = exp_q.pop_front();
                    check("colour_bits", {r0, g0, b0, r1, g1, b1}, e);
                end
            end
            if (latch) begin
                check("latch_edges", edges, N);
                check("latch_row_select", row_select, m_row);
                check("latch_width", prev_latch, 0);
                check("latch_oe_n", oe_n, 1);
            end
            prev_dv = img.row_0_data_valid;
            prev_sc = sc;
            prev_oe = oe_n;
            prev_latch = latch;
        end
    end

    task automatic check_reset_values();
        check("rst_address_0", img.row_0_pixel_address, 0);
        check("rst_address_1", img.row_1_pixel_address, 0);
        check("rst_valid_0", img.row_0_data_valid, 0);
        check("rst_valid_1", img.row_1_data_valid, 0);
        check("rst_colours", {r0, g0, b0, r1, g1, b1}, 0);
        check("rst_shift_clk", sc, 0);
        check("rst_latch", latch, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_row_select", row_select, 0);
        check("rst_frame_done", frame_done, 0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_reached", frame_count >= target, 1);
    endtask

    task automatic wait_row(input int row, input int budget);
        int n = 0;
        while (m_row != row && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("row_reached", m_row == row, 1);
    endtask

    initial begin : stimulus
        int starts_at_idle;
        int n;
        // Reset held for 3 cycles with enable high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("held_before_start", img.row_0_data_valid, 0);
        @(negedge clk);
        check("first_valid", img.row_0_data_valid, 1);
        check("first_address", img.row_0_pixel_address, 0);

        // Full first frame, then wrap back to address 0.
        wait_frames(1, 33000);
        check("wrap_address", img.row_0_pixel_address, 0);
        check("wrap_valid", img.row_0_data_valid, 1);

        // Enable drop during row 5: frame completes, then IDLE.
        wait_row(5, 12000);
        @(posedge clk); #1 enable = 1'b0;
        wait_frames(2, 25000);
        check("idle_oe_n", oe_n, 1);
        check("idle_valid", img.row_0_data_valid, 0);
        starts_at_idle = shift_starts;
        repeat (300) @(negedge clk);
        check("idle_address", img.row_0_pixel_address, last_exp_addr);
        check("idle_no_shift", shift_starts, starts_at_idle);
        check("idle_oe_n_held", oe_n, 1);

        // Mid-shift reset at column 60 of row 3.
        @(posedge clk); #1 enable = 1'b1;
        n = 0;
        while (!(m_row == 3 && img.row_0_data_valid && img.row_0_pixel_address == 11'(3*N + 60)) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("reached_row3_col60", img.row_0_pixel_address, 3*N + 60);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("restart_valid", img.row_0_data_valid, 1);
        check("restart_address", img.row_0_pixel_address, 0);
        wait_row(1, 2500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
